uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter: the transmit end of the serial link used by the loopback and host-link designs.
- Accepts bytes on a valid/ready handshake into an internal FIFO.
- Serialises FIFO bytes LSB-first on txd with no idle gap between queued frames.
- Sits between core logic (e.g. top_loopback, host responders) and the board txd pin. Runs in the 96 MHz PLL domain.

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a circular FIFO on a valid/ready
// handshake and are serialised LSB-first on txd with no gap between queued frames.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQUENCY = 96_000_000,
    parameter int unsigned BAUD          = 12_000_000,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = AW + 1;
    localparam int unsigned TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST     = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          txd_next;
    logic          busy_next;
    logic [CW-1:0] count_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, fifo_empty, bit_done;

    assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = tx_valid && tx_ready;
    assign bit_done   = (timer == T_LAST);

    // Next-state, serial output and FIFO pop decision.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        txd_next     = txd;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    txd_next   = 1'b0;
                    timer_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                    state_next   = DATA;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        txd_next     = shift[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy and busy flag, computed from next-cycle values so both stay registered.
    always_comb begin
        count_next = fifo_count;
        unique case ({push, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
        busy_next = (state_next != IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            txd        <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            txd        <= txd_next;
            fifo_count <= count_next;
            tx_busy    <= busy_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle-exact frame checks plus a line monitor
// that decodes txd mid-bit and queues received bytes.
module tb_uart_tx_fifo;

    localparam int CPB = 8;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_ready2;
    logic       txd, txd2;
    logic       tx_busy, tx_busy2;
    logic [4:0] fifo_count, fifo_count2;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo u_dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLK_FREQUENCY(4), .BAUD(1), .FIFO_DEPTH(16)) u_slow (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .txd        (txd2),
        .tx_busy    (tx_busy2),
        .fifo_count (fifo_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line monitor for the default instance: samples each bit at its midpoint.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    int         rx_cnt = 0;
    bit         rx_act = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB + CPB/2 && rx_cnt <= 8*CPB + CPB/2 && (rx_cnt % CPB) == CPB/2)
                rx_sh = {txd, rx_sh[7:1]};
            if (rx_cnt == 9*CPB + CPB/2) begin
                checks++;
                assert (txd === 1'b1) else begin
                    errors++;
                    $error("FAIL monitor stop bit: observed %b expected 1", txd);
                end
                rx_q.push_back(rx_sh);
            end
            if (rx_cnt == 10*CPB - 1)
                rx_act = 1'b0;
        end
    end

    // Called right after the edge where the start bit begins.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("%s bit%0d cyc%0d", tag, i, c), 32'(txd), 32'(f[i]));
                tick();
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (tx_busy && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " busy cleared"}, 32'(tx_busy), 32'd0);
        chk({tag, " txd idle"}, 32'(txd), 32'd1);
    endtask

    task automatic wait_rx(input int want, input int budget, input string tag);
        int n;
        n = 0;
        while (rx_q.size() < want && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " rx count"}, 32'(rx_q.size()), 32'(want));
    endtask

    initial begin
        int  sent, cyc, first_drop, saw_low;
        bit  pushed;

        reset     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst count", 32'(fifo_count), 32'd0);
        chk("rst busy", 32'(tx_busy), 32'd0);
        chk("rst ready", 32'(tx_ready), 32'd1);
        chk("rst slow txd", 32'(txd2), 32'd1);
        chk("rst slow count", 32'(fifo_count2), 32'd0);

        // Single byte 0x55
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("t1 txd still high at E", 32'(txd), 32'd1);
        chk("t1 count after push", 32'(fifo_count), 32'd1);
        chk("t1 busy after push", 32'(tx_busy), 32'd1);
        tick();
        check_frame(8'h55, "t1 0x55");
        chk("t1 busy low after 80", 32'(tx_busy), 32'd0);
        chk("t1 txd high after frame", 32'(txd), 32'd1);
        repeat (5) tick();
        chk("t1 txd stays high", 32'(txd), 32'd1);

        // Back-to-back 0xA5, 0x3C
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h3C;
        tick();
        tx_valid = 1'b0;
        check_frame(8'hA5, "t2 0xA5");
        check_frame(8'h3C, "t2 0x3C");
        chk("t2 busy low after 160", 32'(tx_busy), 32'd0);

        // Streaming 20 bytes with tx_valid held high
        rx_q.delete();
        sent       = 0;
        cyc        = 0;
        first_drop = -1;
        while (sent < 20 && cyc < 3000) begin
            tx_data  = 8'(sent);
            tx_valid = 1'b1;
            pushed   = tx_ready;
            if (!tx_ready && first_drop < 0) begin
                first_drop = sent;
                chk("t3 count at full", 32'(fifo_count), 32'd16);
            end
            tick();
            if (pushed) sent++;
            cyc++;
        end
        tx_valid = 1'b0;
        chk("t3 accepted before ready drop", 32'(first_drop), 32'd17);
        chk("t3 all accepted", 32'(sent), 32'd20);
        wait_rx(20, 3000, "t3");
        for (int i = 0; i < 20; i++)
            chk($sformatf("t3 rx byte %0d", i), 32'(rx_q[i]), 32'(i));
        wait_idle(200, "t3");

        // Same-edge push/pop at count 5, pointers wrapping
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            tx_data  = 8'(8'h40 + i);
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        chk("t4 count after 6 pushes", 32'(fifo_count), 32'd5);
        repeat (75) tick();
        chk("t4 count before pop edge", 32'(fifo_count), 32'd5);
        tx_data  = 8'h46;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("t4 count after push+pop", 32'(fifo_count), 32'd5);
        chk("t4 next start bit", 32'(txd), 32'd0);
        sent = 7;
        cyc  = 0;
        while (sent < 20 && cyc < 3000) begin
            tx_data  = 8'(8'h40 + sent);
            tx_valid = 1'b1;
            pushed   = tx_ready;
            tick();
            if (pushed) sent++;
            cyc++;
        end
        tx_valid = 1'b0;
        wait_rx(20, 3000, "t4");
        for (int i = 0; i < 20; i++)
            chk($sformatf("t4 rx byte %0d", i), 32'(rx_q[i]), 32'(8'h40 + i));
        wait_idle(200, "t4");

        // Reset in the middle of the second of three frames
        rx_q.delete();
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        tick();
        tx_data = 8'h22;
        tick();
        tx_data = 8'h33;
        tick();
        tx_valid = 1'b0;
        repeat (118) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5 txd after reset", 32'(txd), 32'd1);
        chk("t5 count after reset", 32'(fifo_count), 32'd0);
        chk("t5 busy after reset", 32'(tx_busy), 32'd0);
        chk("t5 ready after reset", 32'(tx_ready), 32'd1);
        saw_low = 0;
        repeat (200) begin
            if (txd !== 1'b1) saw_low = 1;
            tick();
        end
        chk("t5 no frames after reset", 32'(saw_low), 32'd0);
        chk("t5 rx count", 32'(rx_q.size()), 32'd1);
        chk("t5 first byte intact", 32'(rx_q[0]), 32'h11);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("t5 txd high at E", 32'(txd), 32'd1);
        tick();
        check_frame(8'h81, "t5 0x81");
        chk("t5 busy low", 32'(tx_busy), 32'd0);
        chk("t5 rx 0x81", 32'(rx_q[rx_q.size()-1]), 32'h81);

        // CLKS_PER_BIT = 4 instance, byte 0xFF
        tx_data2  = 8'hFF;
        tx_valid2 = 1'b1;
        chk("t6 ready before push", 32'(tx_ready2), 32'd1);
        tick();
        tx_valid2 = 1'b0;
        chk("t6 txd high at E", 32'(txd2), 32'd1);
        chk("t6 count after push", 32'(fifo_count2), 32'd1);
        tick();
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("t6 txd cyc%0d", c), 32'(txd2), (c < 4) ? 32'd0 : 32'd1);
            chk($sformatf("t6 ready cyc%0d", c), 32'(tx_ready2), 32'd1);
            tick();
        end
        chk("t6 busy low", 32'(tx_busy2), 32'd0);
        chk("t6 count empty", 32'(fifo_count2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
